// File: rtl/reg_file_pkg.sv
// ============================================================================
// Module : reg_file_pkg
// Brief  : Shared defaults and bus-slicing helper for the scoreboarded
//          register file.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package reg_file_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_ADDR_W = 5;
   localparam int DEF_NUM_RD = 2;
   localparam int ZERO_ADDR  = 0;

   // LSB position of lane 'port' in a flattened bus of 'width'-bit lanes.
   function automatic int slice_lsb(input int port, input int width);
      return port * width;
   endfunction

endpackage

`default_nettype wire

// File: rtl/reg_sb.sv
// ============================================================================
// Module : reg_sb
// Brief  : Per-register busy scoreboard with reserve-over-clear priority.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module reg_sb
   import reg_file_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int ZERO_REG = 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   wr0_en,
   input  logic [ADDR_W-1:0]      wr0_addr,
   input  logic                   wr1_en,
   input  logic [ADDR_W-1:0]      wr1_addr,
   input  logic                   rsv_en,
   input  logic [ADDR_W-1:0]      rsv_addr,
   output logic [(2**ADDR_W)-1:0] busy,
   output logic                   all_idle
);

   localparam int DEPTH = 2**ADDR_W;

   logic [DEPTH-1:0] busy_q;
   logic [DEPTH-1:0] busy_d;

   // Reserve is applied last so a newly issued producer outranks a retiring one.
   always_comb begin
      busy_d = busy_q;
      if (wr0_en) busy_d[wr0_addr] = 1'b0;
      if (wr1_en) busy_d[wr1_addr] = 1'b0;
      if (rsv_en) busy_d[rsv_addr] = 1'b1;
      if (ZERO_REG != 0) busy_d[ZERO_ADDR] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) busy_q <= '0;
      else       busy_q <= busy_d;
   end

   assign busy     = busy_q;
   assign all_idle = reset | ~(|busy_q);

endmodule

`default_nettype wire

// File: rtl/reg_file_sb.sv
// ============================================================================
// Module : reg_file_sb
// Brief  : Dual-write, multi-read register file with optional bypass and a
//          busy scoreboard for RAW hazard detection.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module reg_file_sb
   import reg_file_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int NUM_RD   = DEF_NUM_RD,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     write0,
   input  logic [ADDR_W-1:0]        write_reg0,
   input  logic [DATA_W-1:0]        write_data0,
   input  logic                     write1,
   input  logic [ADDR_W-1:0]        write_reg1,
   input  logic [DATA_W-1:0]        write_data1,
   input  logic [NUM_RD*ADDR_W-1:0] read_reg,
   output logic [NUM_RD*DATA_W-1:0] data_out,
   output logic [NUM_RD-1:0]        busy_out,
   input  logic                     reserve,
   input  logic [ADDR_W-1:0]        reserve_reg,
   output logic                     all_idle
);

   localparam int DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [DEPTH-1:0]  w_busy;

   // Port 1 is applied second so it wins a same-address collision.
   always_comb begin
      mem_d = mem_q;
      if (write0) mem_d[write_reg0] = write_data0;
      if (write1) mem_d[write_reg1] = write_data1;
      if (ZERO_REG != 0) mem_d[ZERO_ADDR] = '0;
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (reset) mem_q[i] <= '0;
         else       mem_q[i] <= mem_d[i];
      end
   end

   reg_sb #(
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
   ) u_reg_sb (
      .clk      (clk),
      .reset    (reset),
      .wr0_en   (write0),
      .wr0_addr (write_reg0),
      .wr1_en   (write1),
      .wr1_addr (write_reg1),
      .rsv_en   (reserve),
      .rsv_addr (reserve_reg),
      .busy     (w_busy),
      .all_idle (all_idle)
   );

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] w_raddr;
      logic [DATA_W-1:0] w_rdata;
      logic              w_rbusy;
      logic              w_hit0;
      logic              w_hit1;

      assign w_raddr = read_reg[slice_lsb(k, ADDR_W) +: ADDR_W];
      assign w_hit0  = write0 && (write_reg0 == w_raddr);
      assign w_hit1  = write1 && (write_reg1 == w_raddr);

      // Reset blanks the ports so in-flight writes never leak out during it.
      always_comb begin
         w_rdata = mem_q[w_raddr];
         w_rbusy = w_busy[w_raddr];
         if (BYPASS != 0) begin
            if (w_hit1)      w_rdata = write_data1;
            else if (w_hit0) w_rdata = write_data0;
            if (w_hit0 || w_hit1) w_rbusy = 1'b0;
         end
         if ((ZERO_REG != 0) && (w_raddr == ADDR_W'(ZERO_ADDR))) begin
            w_rdata = '0;
            w_rbusy = 1'b0;
         end
         if (reset) begin
            w_rdata = '0;
            w_rbusy = 1'b0;
         end
      end

      assign data_out[slice_lsb(k, DATA_W) +: DATA_W] = w_rdata;
      assign busy_out[k] = w_rbusy;
   end

endmodule

`default_nettype wire

// File: tb/tb_reg_file_sb.sv
// ============================================================================
// Module : tb_reg_file_sb
// Brief  : Directed self-checking bench; bypassed and non-bypassed instances
//          share stimulus.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_reg_file_sb;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NR = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic          write0, write1, reserve;
   logic [AW-1:0] write_reg0, write_reg1, reserve_reg;
   logic [DW-1:0] write_data0, write_data1;
   logic [NR*AW-1:0] read_reg;
   logic [NR*DW-1:0] data_bp, data_nb;
   logic [NR-1:0]    busy_bp, busy_nb;
   logic             idle_bp, idle_nb;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   reg_file_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1), .BYPASS(1)) dut (
      .clk(clk), .reset(reset),
      .write0(write0), .write_reg0(write_reg0), .write_data0(write_data0),
      .write1(write1), .write_reg1(write_reg1), .write_data1(write_data1),
      .read_reg(read_reg), .data_out(data_bp), .busy_out(busy_bp),
      .reserve(reserve), .reserve_reg(reserve_reg), .all_idle(idle_bp)
   );

   reg_file_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1), .BYPASS(0)) dut_nb (
      .clk(clk), .reset(reset),
      .write0(write0), .write_reg0(write_reg0), .write_data0(write_data0),
      .write1(write1), .write_reg1(write_reg1), .write_data1(write_data1),
      .read_reg(read_reg), .data_out(data_nb), .busy_out(busy_nb),
      .reserve(reserve), .reserve_reg(reserve_reg), .all_idle(idle_nb)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      write0 = 1'b0; write1 = 1'b0; reserve = 1'b0;
      write_reg0 = '0; write_reg1 = '0; reserve_reg = '0;
      write_data0 = '0; write_data1 = '0;
   endtask

   task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
      read_reg = {a1, a0};
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle_inputs();
      read_reg = '0;
      tick();
      tick();
      reset = 1'b0;
      for (int a = 0; a < 32; a++) begin
         set_rd(AW'(a), AW'(31 - a));
         n_checks++;
         if (data_bp !== '0 || busy_bp !== '0 || data_nb !== '0 || busy_nb !== '0) begin
            n_fail++;
            $display("FAIL reset_read addr=%0d: data_bp=%h busy_bp=%b data_nb=%h busy_nb=%b, want all 0",
                     a, data_bp, busy_bp, data_nb, busy_nb);
         end
      end
      n_checks++;
      if (idle_bp !== 1'b1 || idle_nb !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_idle: got %b/%b want 1/1", idle_bp, idle_nb);
      end
   endtask

   task automatic test_bypass();
      write0 = 1'b1; write_reg0 = 5; write_data0 = 32'hDEADBEEF;
      set_rd(5, 0);
      n_checks++;
      if (data_bp[31:0] !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL bypass_same_cycle: got %h want deadbeef", data_bp[31:0]);
      end
      n_checks++;
      if (data_nb[31:0] !== 32'h0) begin
         n_fail++;
         $display("FAIL nobypass_same_cycle: got %h want 00000000", data_nb[31:0]);
      end
      tick();
      idle_inputs();
      #1;
      n_checks++;
      if (data_nb[31:0] !== 32'hDEADBEEF || data_bp[31:0] !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL write_next_cycle: got %h/%h want deadbeef", data_bp[31:0], data_nb[31:0]);
      end
   endtask

   task automatic test_same_addr();
      write0 = 1'b1; write_reg0 = 7; write_data0 = 32'h11;
      write1 = 1'b1; write_reg1 = 7; write_data1 = 32'h22;
      set_rd(0, 7);
      n_checks++;
      if (data_bp[63:32] !== 32'h22) begin
         n_fail++;
         $display("FAIL collide_bypass: got %h want 00000022", data_bp[63:32]);
      end
      tick();
      idle_inputs();
      #1;
      n_checks++;
      if (data_bp[63:32] !== 32'h22 || data_nb[63:32] !== 32'h22) begin
         n_fail++;
         $display("FAIL collide_stored: got %h/%h want 00000022", data_bp[63:32], data_nb[63:32]);
      end
   endtask

   task automatic test_reserve();
      reserve = 1'b1; reserve_reg = 9;
      set_rd(9, 0);
      tick();
      idle_inputs();
      for (int c = 0; c < 2; c++) begin
         #1;
         n_checks++;
         if (busy_bp[0] !== 1'b1 || busy_nb[0] !== 1'b1 || idle_bp !== 1'b0) begin
            n_fail++;
            $display("FAIL reserve_busy cyc=%0d: busy=%b/%b idle=%b want 1/1 idle 0",
                     c, busy_bp[0], busy_nb[0], idle_bp);
         end
         tick();
      end
      write1 = 1'b1; write_reg1 = 9; write_data1 = 32'h5;
      #1;
      n_checks++;
      if (busy_bp[0] !== 1'b0 || busy_nb[0] !== 1'b1 || data_bp[31:0] !== 32'h5 || idle_bp !== 1'b0) begin
         n_fail++;
         $display("FAIL write_clears_busy: busy=%b/%b data=%h idle=%b want 0/1 00000005 idle 0",
                  busy_bp[0], busy_nb[0], data_bp[31:0], idle_bp);
      end
      tick();
      idle_inputs();
      #1;
      n_checks++;
      if (idle_bp !== 1'b1 || busy_nb[0] !== 1'b0 || data_nb[31:0] !== 32'h5) begin
         n_fail++;
         $display("FAIL after_clear: idle=%b busy_nb=%b data_nb=%h want 1 0 00000005",
                  idle_bp, busy_nb[0], data_nb[31:0]);
      end
   endtask

   task automatic test_reserve_write();
      reserve = 1'b1; reserve_reg = 3;
      write0 = 1'b1; write_reg0 = 3; write_data0 = 32'hA;
      set_rd(3, 0);
      tick();
      idle_inputs();
      #1;
      n_checks++;
      if (data_bp[31:0] !== 32'hA || busy_bp[0] !== 1'b1 || busy_nb[0] !== 1'b1 || idle_bp !== 1'b0) begin
         n_fail++;
         $display("FAIL reserve_wins: data=%h busy=%b/%b idle=%b want 0000000a 1/1 idle 0",
                  data_bp[31:0], busy_bp[0], busy_nb[0], idle_bp);
      end
      write0 = 1'b1; write_reg0 = 0; write_data0 = 32'hFF;
      write1 = 1'b1; write_reg1 = 0; write_data1 = 32'hEE;
      reserve = 1'b1; reserve_reg = 0;
      set_rd(0, 0);
      n_checks++;
      if (data_bp !== '0 || busy_bp !== '0) begin
         n_fail++;
         $display("FAIL zero_reg_bypass: data=%h busy=%b want 0", data_bp, busy_bp);
      end
      tick();
      idle_inputs();
      #1;
      n_checks++;
      if (data_bp !== '0 || busy_bp !== '0 || data_nb !== '0 || busy_nb !== '0) begin
         n_fail++;
         $display("FAIL zero_reg_stored: data=%h/%h busy=%b/%b want 0",
                  data_bp, data_nb, busy_bp, busy_nb);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++) begin
         write0 = 1'b1; write_reg0 = AW'(10 + i); write_data0 = 32'hA0 + 32'(i);
         write1 = 1'b1; write_reg1 = AW'(16 + i); write_data1 = 32'hB0 + 32'(i);
         tick();
      end
      idle_inputs();
      for (int i = 0; i < 4; i++) begin
         set_rd(AW'(10 + i), AW'(16 + i));
         n_checks++;
         if (data_nb !== {32'hB0 + 32'(i), 32'hA0 + 32'(i)} || data_bp !== data_nb) begin
            n_fail++;
            $display("FAIL back_to_back i=%0d: got %h/%h want %h%h", i, data_bp, data_nb,
                     32'hB0 + 32'(i), 32'hA0 + 32'(i));
         end
      end
   endtask

   task automatic test_reset_midstream();
      for (int r = 1; r <= 4; r++) begin
         reserve = 1'b1; reserve_reg = AW'(r);
         tick();
      end
      idle_inputs();
      write0 = 1'b1; write_reg0 = 2; write_data0 = 32'h77;
      tick();
      idle_inputs();
      set_rd(2, 4);
      n_checks++;
      if (data_nb[31:0] !== 32'h77 || busy_nb !== 2'b10 || idle_bp !== 1'b0) begin
         n_fail++;
         $display("FAIL pre_reset: data=%h busy=%b idle=%b want 00000077 10 idle 0",
                  data_nb[31:0], busy_nb, idle_bp);
      end
      reset = 1'b1;
      write0 = 1'b1; write_reg0 = 6; write_data0 = 32'h66;
      reserve = 1'b1; reserve_reg = 6;
      tick();
      reset = 1'b0;
      idle_inputs();
      for (int r = 1; r <= 6; r++) begin
         set_rd(AW'(r), 2);
         n_checks++;
         if (busy_bp !== '0 || busy_nb !== '0 || data_nb !== '0 || data_bp !== '0) begin
            n_fail++;
            $display("FAIL post_reset r=%0d: data=%h/%h busy=%b/%b want 0",
                     r, data_bp, data_nb, busy_bp, busy_nb);
         end
      end
      n_checks++;
      if (idle_bp !== 1'b1 || idle_nb !== 1'b1) begin
         n_fail++;
         $display("FAIL post_reset_idle: got %b/%b want 1/1", idle_bp, idle_nb);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_bypass();
      test_same_addr();
      test_reserve();
      test_reserve_write();
      test_back_to_back();
      test_reset_midstream();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
